flash_sample_fetcher: RTL and testbench

Upstream stage of the audio player: walks a word range of the Avalon-MM flash, issues one 32-bit read per word and holds the word stable for the player. It then hands the word over with a `start_audio` / `audio_done` handshake and advances only once the player has consumed all four samples. It runs on the 50 MHz system clock and synchronizes the player's slow-domain `audio_done` internally.

---
 rtl/flash_sample_fetcher.sv | 163 ++++++++++++++++
 tb/tb_flash_sample_fetcher.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_sample_fetcher.sv
// flash_sample_fetcher
//   Walks an inclusive word range of the Avalon-MM flash. For each word it
//   issues a single 32-bit read and latches the returned data on sample_word.
//   It then hands the word to the audio player with a start_audio/audio_done
//   handshake, and moves to the next address once the player is idle again.
//
// Ports
//   clk, reset_n             system clock, async active-low reset
//   start, start_addr,       one-cycle start pulse plus the inclusive range;
//   end_addr                 the range is sampled on the accepted start
//   play_en                  0 pauses before the next flash read
//   audio_done               player-idle level from the slow domain
//                            (async, synchronized here)
//   flash_mem_*              Avalon-MM read master (word addressed)
//   sample_word              latched flash word, stable during hand-off/play
//   start_audio              request level to the player
//   busy, done               range in progress / one-cycle completion pulse
module flash_sample_fetcher #(
    parameter int ADDR_W = 23
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              play_en,
    input  logic              audio_done,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [31:0]       flash_mem_readdata,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [31:0]       sample_word,
    output logic              start_audio,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_REQ, S_WAIT, S_HAND, S_PLAY, S_NEXT
    } state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] end_q, end_n;
    logic              rd_q, rd_n;
    logic [31:0]       sw_q, sw_n;
    logic              sa_q, sa_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;

    // Two-flop synchronizer for the slow-domain idle level. Both flops reset
    // to 1 so that the player looks idle straight out of reset.
    logic sync1_q, done_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            done_s  <= 1'b1;
        end else begin
            sync1_q <= audio_done;
            done_s  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            rd_q    <= 1'b0;
            sw_q    <= '0;
            sa_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            end_q   <= end_n;
            rd_q    <= rd_n;
            sw_q    <= sw_n;
            sa_q    <= sa_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        end_n   = end_q;
        rd_n    = rd_q;
        sw_n    = sw_q;
        sa_n    = sa_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_n  = start_addr;
                    end_n   = end_addr;
                    busy_n  = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                // play_en gates only the next read. A word that has already
                // been handed over always finishes playing.
                if (play_en) begin
                    rd_n    = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (!flash_mem_waitrequest) begin
                    rd_n    = 1'b0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only this state captures data, so stray readdatavalid pulses
                // in other states cannot corrupt the word being played.
                if (flash_mem_readdatavalid) begin
                    sw_n    = flash_mem_readdata;
                    state_n = S_HAND;
                end
            end
            S_HAND: begin
                sa_n = 1'b1;
                if (!done_s) begin
                    sa_n    = 1'b0;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (done_s) state_n = S_NEXT;
            end
            S_NEXT: begin
                // Equality compare, with the address wrapping at all-ones, so
                // a start above the end wraps through 0 up to end_addr.
                if (addr_q == end_q) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    addr_n  = addr_q + 1'b1;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign flash_mem_read       = rd_q;
    assign flash_mem_address    = addr_q;
    assign flash_mem_byteenable = 4'b1111;
    assign sample_word          = sw_q;
    assign start_audio          = sa_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Directed bench for flash_sample_fetcher. It uses a behavioural flash
// (programmable waitrequest and readdatavalid latency) and a scaled-down
// slow-clock player model.
module tb_flash_sample_fetcher;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr, end_addr;
    logic          play_en;
    logic          audio_done;
    logic          wr, rdv;
    logic [31:0]   rdata;
    logic          flash_mem_read;
    logic [AW-1:0] flash_mem_address;
    logic [3:0]    flash_mem_byteenable;
    logic [31:0]   sample_word;
    logic          start_audio, busy, done;

    int total = 0;
    int bad   = 0;

    flash_sample_fetcher #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .start_addr              (start_addr),
        .end_addr                (end_addr),
        .play_en                 (play_en),
        .audio_done              (audio_done),
        .flash_mem_waitrequest   (wr),
        .flash_mem_readdatavalid (rdv),
        .flash_mem_readdata      (rdata),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .sample_word             (sample_word),
        .start_audio             (start_audio),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    // ---------------- flash model ----------------
    int            wait_cycles = 0;
    int            rdv_lat     = 1;
    int            wr_cnt;
    int            lat_cnt;
    logic          pend;
    logic [AW-1:0] pend_addr;
    logic          rdv_q;
    logic [31:0]   rdata_q;
    logic          stray = 1'b0;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        if (a == 23'h000100) return 32'hA1B2C3D4;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign wr    = flash_mem_read && (wr_cnt < wait_cycles);
    assign rdv   = rdv_q | stray;
    assign rdata = stray ? 32'hDEADBEEF : rdata_q;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= 0; lat_cnt <= 0; pend <= 1'b0; pend_addr <= '0;
            rdv_q <= 1'b0; rdata_q <= '0;
        end else begin
            rdv_q <= 1'b0;
            if (flash_mem_read && wr) wr_cnt <= wr_cnt + 1;
            else if (flash_mem_read) begin
                wr_cnt    <= 0;
                pend      <= 1'b1;
                lat_cnt   <= rdv_lat - 1;
                pend_addr <= flash_mem_address;
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    rdv_q   <= 1'b1;
                    rdata_q <= word_of(pend_addr);
                    pend    <= 1'b0;
                end else lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // ---------------- player model (slow tick every 16 clk) ----------------
    int div, scnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_done <= 1'b1; div <= 0; scnt <= 0;
        end else if (div == 15) begin
            div <= 0;
            if (audio_done) begin
                if (start_audio) begin audio_done <= 1'b0; scnt <= 3; end
            end else if (scnt == 0) audio_done <= 1'b1;
            else scnt <= scnt - 1;
        end else div <= div + 1;
    end

    // ---------------- monitors ----------------
    logic [AW-1:0] rd_log[$];
    logic [31:0]   cap_log[$];
    int            addr_err = 0, sa_err = 0, stab_err = 0, db_err = 0, done_cnt = 0;
    logic          p_read = 0, p_sa = 0, p_done = 0, watch = 0, seen_low = 0;
    logic [AW-1:0] p_addr = '0;
    logic [31:0]   sw_ref = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (flash_mem_read && !wr) rd_log.push_back(flash_mem_address);
            if (flash_mem_read && p_read && flash_mem_address != p_addr) addr_err <= addr_err + 1;
            if (p_sa && !start_audio && audio_done) sa_err <= sa_err + 1;
            if (!p_sa && start_audio) begin
                cap_log.push_back(sample_word);
                sw_ref   <= sample_word;
                watch    <= 1'b1;
                seen_low <= 1'b0;
            end else if (watch) begin
                if (sample_word !== sw_ref) stab_err <= stab_err + 1;
                if (!audio_done) seen_low <= 1'b1;
                else if (seen_low) watch <= 1'b0;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (busy || p_done) db_err <= db_err + 1;
            end
        end
        p_read <= flash_mem_read;
        p_addr <= flash_mem_address;
        p_sa   <= start_audio;
        p_done <= done;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
        @(negedge clk);
        start = 1'b1; start_addr = sa; end_addr = ea;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    // which: 0 = flash_mem_read, 1 = start_audio
    task automatic wait_for(input int which, input logic val, input string tag);
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if ((which == 0 ? flash_mem_read : start_audio) == val) begin seen = 1; break; end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        bit seen = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) begin seen = 1; break; end
        end
        chk(tag, 64'(seen), 64'd1);
        tick(40);
        chk({tag, "_once"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        cap_log.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0; play_en = 1'b1;
        tick(3);
        chk("rst_read",  64'(flash_mem_read), 64'd0);
        chk("rst_addr",  64'(flash_mem_address), 64'd0);
        chk("rst_sw",    64'(sample_word), 64'd0);
        chk("rst_sa",    64'(start_audio), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("byteen",    64'(flash_mem_byteenable), 64'hF);
        reset_n = 1'b1;
        tick(2);

        // Reset asserted while the read is stalled in REQ.
        wait_cycles = 8; rdv_lat = 1;
        pulse_start(23'h000055, 23'h000055);
        wait_for(0, 1'b1, "midreq_read_seen");
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("midreq_read", 64'(flash_mem_read), 64'd0);
        chk("midreq_addr", 64'(flash_mem_address), 64'd0);
        chk("midreq_busy", 64'(busy), 64'd0);
        chk("midreq_sa",   64'(start_audio), 64'd0);
        chk("midreq_done", 64'(done), 64'd0);
        tick(3);
        reset_n = 1'b1;
        tick(3);
        chk("postrst_busy", 64'(busy), 64'd0);
        clear_logs();

        // Single word at 0x100.
        wait_cycles = 2; rdv_lat = 3;
        pulse_start(23'h000100, 23'h000100);
        chk("single_busy", 64'(busy), 64'd1);
        wait_done("single_done");
        chk("single_nrd",  64'(rd_log.size()), 64'd1);
        chk("single_addr", 64'(rd_log[0]), 64'h100);
        chk("single_sw",   64'(sample_word), 64'hA1B2C3D4);
        chk("single_cap",  64'(cap_log[0]), 64'hA1B2C3D4);
        clear_logs();

        // Range 0x10..0x13.
        wait_cycles = 1; rdv_lat = 2;
        pulse_start(23'h000010, 23'h000013);
        wait_done("range_done");
        chk("range_nrd", 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("range_addr%0d", i), 64'(rd_log[i]), 64'(23'h10 + i));
            chk($sformatf("range_cap%0d", i), 64'(cap_log[i]), 64'(32'hC0DE0010 + i));
        end
        clear_logs();

        // Wrap 0x7FFFFE..0x000001.
        wait_cycles = 0; rdv_lat = 1;
        pulse_start(23'h7FFFFE, 23'h000001);
        wait_done("wrap_done");
        chk("wrap_nrd", 64'(rd_log.size()), 64'd4);
        chk("wrap_a0", 64'(rd_log[0]), 64'h7FFFFE);
        chk("wrap_a1", 64'(rd_log[1]), 64'h7FFFFF);
        chk("wrap_a2", 64'(rd_log[2]), 64'h000000);
        chk("wrap_a3", 64'(rd_log[3]), 64'h000001);
        chk("wrap_cap1", 64'(cap_log[1]), 64'hC0DEFFFF);
        clear_logs();

        // Pause during PLAY of the word at 0x11.
        wait_cycles = 1; rdv_lat = 2;
        pulse_start(23'h000010, 23'h000013);
        begin
            bit seen = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk); #1;
                if (rd_log.size() == 2) begin seen = 1; break; end
            end
            chk("pause_2nd_read", 64'(seen), 64'd1);
        end
        wait_for(1, 1'b1, "pause_sa_hi");
        wait_for(1, 1'b0, "pause_sa_lo");
        play_en = 1'b0;
        tick(300);
        chk("pause_nrd",  64'(rd_log.size()), 64'd2);
        chk("pause_idle", 64'(audio_done), 64'd1);
        chk("pause_sw",   64'(sample_word), 64'hC0DE0011);
        chk("pause_busy", 64'(busy), 64'd1);
        chk("pause_read", 64'(flash_mem_read), 64'd0);
        play_en = 1'b1;
        wait_done("pause_done");
        chk("pause_nrd_end", 64'(rd_log.size()), 64'd4);
        chk("pause_a2", 64'(rd_log[2]), 64'h12);
        chk("pause_a3", 64'(rd_log[3]), 64'h13);
        clear_logs();

        // Spurious start while busy and a stray readdatavalid during PLAY.
        pulse_start(23'h000020, 23'h000021);
        pulse_start(23'h000099, 23'h000099);
        wait_for(1, 1'b1, "spur_sa_hi");
        wait_for(1, 1'b0, "spur_sa_lo");
        tick(5);
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        #1;
        tick(2);
        chk("spur_sw_play", 64'(sample_word), 64'hC0DE0020);
        wait_done("spur_done");
        chk("spur_nrd", 64'(rd_log.size()), 64'd2);
        chk("spur_a0",  64'(rd_log[0]), 64'h20);
        chk("spur_a1",  64'(rd_log[1]), 64'h21);
        chk("spur_cap1", 64'(cap_log[1]), 64'hC0DE0021);

        // Properties watched across every test above.
        chk("addr_stable_while_read", 64'(addr_err), 64'd0);
        chk("sa_held_until_ack",      64'(sa_err), 64'd0);
        chk("word_stable_in_play",    64'(stab_err), 64'd0);
        chk("done_pulse_shape",       64'(db_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
